// File: rtl/mc_fetch_mem_unit.sv
// Fetch/memory unit for a multicycle RISC-V core. It holds PC, OldPC, IR and MDR,
// runs single-outstanding req/gnt/rvalid transactions, and decodes op/funct3/funct7[5].
// Ports: command inputs (fetch/load/store, addr, wdata, pc_write/pc_next), architectural
// state outputs (pc, old_pc, instr, fields, data), status (busy, done, err), memory bus.
module mc_fetch_mem_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_i,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        pc_write_i,
  input  logic [31:0] pc_next_i,
  output logic [31:0] pc_o,
  output logic [31:0] old_pc_o,
  output logic [31:0] instr_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_o,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;
  typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_e;

  state_e        state_q, state_d;
  kind_e         kind_q, kind_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   old_pc_q, old_pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [31:0]   mdr_q, mdr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   sel_addr;
  logic          timeout;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    pc_d       = pc_q;
    old_pc_d   = old_pc_q;
    ir_d       = ir_q;
    mdr_d      = mdr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    done_d     = 1'b0;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q + WW'(1);
    sel_addr   = fetch_i ? pc_q : addr_i;
    timeout    = (wait_cnt_q == WW'(MAX_WAIT - 1));

    // PC is owned by the datapath's pc_write regardless of bus activity.
    if (pc_write_i) pc_d = pc_next_i;

    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        if (fetch_i || load_i || store_i) begin
          if (sel_addr[1:0] != 2'b00) begin
            // Misaligned: flag and complete immediately without touching the bus.
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            addr_d  = sel_addr;
            wdata_d = wdata_i;
            we_d    = !fetch_i && !load_i;
            kind_d  = fetch_i ? K_FETCH : (load_i ? K_LOAD : K_STORE);
            if (fetch_i) old_pc_d = pc_q;  // pre-update PC even if pc_write_i is set
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          state_d    = ST_RESP;
          wait_cnt_d = '0;
        end else if (timeout) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          if (kind_q == K_FETCH) ir_d  = mem_rdata_i;
          if (kind_q == K_LOAD)  mdr_d = mem_rdata_i;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      kind_q     <= K_FETCH;
      pc_q       <= RESET_PC;
      old_pc_q   <= '0;
      ir_q       <= '0;
      mdr_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      pc_q       <= pc_d;
      old_pc_q   <= old_pc_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign pc_o        = pc_q;
  assign old_pc_o    = old_pc_q;
  assign instr_o     = ir_q;
  assign op_o        = ir_q[6:0];
  assign funct3_o    = ir_q[14:12];
  assign funct7_o    = ir_q[30];
  assign data_o      = mdr_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  // Request is a pure state decode, so it falls on the same edge that samples gnt.
  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mc_fetch_mem_unit.sv
module tb_mc_fetch_mem_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MW     = 4;

  logic        clk_i = 1'b0;
  logic        rst_i, fetch_i, load_i, store_i, pc_write_i;
  logic [31:0] addr_i, wdata_i, pc_next_i;
  logic [31:0] pc_o, old_pc_o, instr_o, data_o;
  logic [6:0]  op_o;
  logic [2:0]  funct3_o;
  logic        funct7_o, busy_o, done_o, err_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_gnt_i, mem_rvalid_i;

  mc_fetch_mem_unit #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fetch_i(fetch_i), .load_i(load_i), .store_i(store_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .pc_write_i(pc_write_i), .pc_next_i(pc_next_i),
    .pc_o(pc_o), .old_pc_o(old_pc_o), .instr_o(instr_o), .op_o(op_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .data_o(data_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] old_pc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Architectural model: what the unit should hold after each completed command.
  logic [31:0] m_pc, m_ir, m_mdr, m_old;
  logic        m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every done pulse retires the oldest expected outcome.
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_done = 1'b0;
      end else if (done_o) begin
        chk1("done_single_pulse", prev_done, 1'b0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done with nothing outstanding want none");
        end else begin
          e = sb.pop_front();
          chk("instr", instr_o, e.ir);
          chk("op", {25'b0, op_o}, {25'b0, e.ir[6:0]});
          chk("funct3", {29'b0, funct3_o}, {29'b0, e.ir[14:12]});
          chk1("funct7", funct7_o, e.ir[30]);
          chk("mdr", data_o, e.mdr);
          chk("old_pc", old_pc_o, e.old_pc);
          chk1("err", err_o, e.err);
          chk1("busy_at_done", busy_o, 1'b0);
        end
      end
      if (!rst_i) prev_done = done_o;
    end
  end

  task automatic set_pc(input logic [31:0] v);
    pc_write_i = 1'b1;
    pc_next_i  = v;
    tick();
    pc_write_i = 1'b0;
    m_pc = v;
    chk("set_pc", pc_o, m_pc);
  endtask

  // Drives one command and plays the memory side with the given gnt/rvalid delays.
  // A gnt delay of MW or more lets the request time out.
  task automatic txn(input logic f, input logic l, input logic s,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                     input int gd, input int rvd, input logic pcw, input logic [31:0] pcn);
    logic [31:0] sel;
    logic        mis, we, is_f, is_l;
    exp_t        e;
    is_f = f;
    is_l = !f && l;
    we   = !f && !l && s;
    sel  = f ? m_pc : addr;
    mis  = (sel[1:0] != 2'b00);
    e.ir = m_ir; e.mdr = m_mdr; e.old_pc = m_old; e.err = m_err;
    if (is_f && !mis) e.old_pc = m_pc;
    if (mis || gd >= MW) e.err = 1'b1;
    else begin
      if (is_f) e.ir = rd;
      if (is_l) e.mdr = rd;
    end
    sb.push_back(e);

    fetch_i = f; load_i = l; store_i = s; addr_i = addr; wdata_i = wd;
    pc_write_i = pcw; pc_next_i = pcn;
    if (pcw) m_pc = pcn;
    tick();
    fetch_i = 1'b0; load_i = 1'b0; store_i = 1'b0; pc_write_i = 1'b0;
    chk("pc_after_cmd", pc_o, m_pc);

    if (mis) begin
      chk1("mis_req", mem_req_o, 1'b0);
      chk1("mis_busy", busy_o, 1'b0);
      tick();
      chk1("mis_req_later", mem_req_o, 1'b0);
    end else begin
      chk1("req_busy", busy_o, 1'b1);
      chk1("req_we", mem_we_o, we);
      if (we) chk("req_wdata", mem_wdata_o, wd);
      if (is_f) chk("fetch_old_pc", old_pc_o, e.old_pc);
      for (int i = 0; i < gd && i < MW; i++) begin
        chk1("req_held", mem_req_o, 1'b1);
        chk("req_addr", mem_addr_o, sel);
        tick();
      end
      if (gd >= MW) begin
        chk1("timeout_req", mem_req_o, 1'b0);
        chk1("timeout_busy", busy_o, 1'b0);
      end else begin
        chk1("req_high", mem_req_o, 1'b1);
        chk("req_addr_gnt", mem_addr_o, sel);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        chk1("resp_req_low", mem_req_o, 1'b0);
        for (int i = 0; i < rvd; i++) begin
          chk1("resp_busy", busy_o, 1'b1);
          chk("resp_mdr_old", data_o, m_mdr);
          chk("resp_ir_old", instr_o, m_ir);
          tick();
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd;
        tick();
        mem_rvalid_i = 1'b0;
        chk1("after_rvalid_busy", busy_o, 1'b0);
      end
    end
    m_ir = e.ir; m_mdr = e.mdr; m_old = e.old_pc; m_err = e.err;
    tick();
  endtask

  initial begin
    logic f, l, s, pcw;
    logic [31:0] a;
    rst_i = 1'b1;
    fetch_i = 1'b0; load_i = 1'b0; store_i = 1'b0; pc_write_i = 1'b0;
    addr_i = '0; wdata_i = '0; pc_next_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    m_pc = RST_PC; m_ir = '0; m_mdr = '0; m_old = '0; m_err = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_ir", instr_o, 32'h0);
    chk("rst_mdr", data_o, 32'h0);
    chk("rst_old_pc", old_pc_o, 32'h0);
    chk("rst_op", {25'b0, op_o}, 32'h0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    chk1("rst_req", mem_req_o, 1'b0);
    chk1("rst_we", mem_we_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    rst_i = 1'b0;
    tick();

    // Zero-wait fetch, then a load with gnt/rvalid wait states.
    set_pc(32'h10);
    txn(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0050_0093, 0, 0, 1'b0, 32'h0);
    chk("fetch_op_0x13", {25'b0, op_o}, 32'h13);
    txn(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 32'hCAFE_F00D, 3, 2, 1'b0, 32'h0);
    // Store with a concurrent fetch: fetch wins. Then a real store.
    txn(1'b1, 1'b0, 1'b1, 32'h300, 32'h1234_5678, 32'h4000_0033, 0, 1, 1'b0, 32'h0);
    txn(1'b0, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 32'h5555_5555, 1, 1, 1'b0, 32'h0);

    // Randomised aligned traffic, with random command overlap and PC writes.
    for (int n = 0; n < 40; n++) begin
      f = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      if (!f && !l && !s) l = 1'b1;
      pcw = 1'($urandom_range(0, 3) == 0);
      a = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      txn(f, l, s, a, $urandom, $urandom, $urandom_range(0, MW - 1),
          $urandom_range(0, MW - 1), pcw, {20'b0, 10'($urandom_range(0, 1023)), 2'b00});
    end

    // Misaligned load, then a timeout with gnt held low.
    txn(1'b0, 1'b1, 1'b0, 32'h102, 32'h0, 32'h0, 0, 0, 1'b0, 32'h0);
    chk1("err_sticky", err_o, 1'b1);
    txn(1'b0, 1'b1, 1'b0, 32'h108, 32'h0, 32'h0, MW, 0, 1'b0, 32'h0);
    // Fetch accepted in the same cycle as a PC write.
    set_pc(32'h20);
    txn(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0013, 0, 0, 1'b1, 32'h80);
    chk("overlap_old_pc", old_pc_o, 32'h20);
    chk("overlap_pc", pc_o, 32'h80);

    // Reset in the middle of a fetch's response phase; the late rvalid is ignored.
    set_pc(32'h40);
    fetch_i = 1'b1;
    tick();
    fetch_i = 1'b0;
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst_pc", pc_o, RST_PC);
    chk1("midrst_busy", busy_o, 1'b0);
    chk("midrst_ir", instr_o, 32'h0);
    chk1("midrst_err", err_o, 1'b0);
    chk1("midrst_req", mem_req_o, 1'b0);
    tick();
    rst_i = 1'b0;
    m_pc = RST_PC; m_ir = '0; m_mdr = '0; m_old = '0; m_err = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hAAAA_5555;
    tick();
    mem_rvalid_i = 1'b0;
    tick();
    chk("late_rvalid_ir", instr_o, 32'h0);
    chk1("late_rvalid_busy", busy_o, 1'b0);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
